// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: frames one N-bit transfer per accepted start
// with programmable CS lead/lag/gap and an SCK divider slow enough for a synchronizing slave.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | CS high, waiting for start
// LEAD     | CS low, SCK low, CS_LEAD cycles before the first bit
// SHIFT_LO | SCK low half of a bit, MOSI holds the current bit
// SHIFT_HI | SCK high half of a bit, MISO captured in its first cycle
// LAG      | CS low, SCK low, CS_LAG cycles; rx word published at the end
// GAP      | CS high, still busy, CS_GAP cycles before returning to IDLE
module spi_master #(
    parameter int N       = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_LEAD = 8,
    parameter int CS_LAG  = 4,
    parameter int CS_GAP  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] tx_data,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rx_data,
    output logic         SCK,
    output logic         MOSI,
    output logic         CS,
    input  logic         MISO
);

    localparam int M1   = (CLK_DIV > CS_LEAD) ? CLK_DIV : CS_LEAD;
    localparam int M2   = (CS_LAG > CS_GAP) ? CS_LAG : CS_GAP;
    localparam int PMAX = (M1 > M2) ? M1 : M2;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int BW   = $clog2(N + 1);

    localparam logic [PW-1:0] LD_LEAD = PW'(CS_LEAD - 1);
    localparam logic [PW-1:0] LD_DIV  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LD_LAG  = PW'(CS_LAG - 1);
    localparam logic [PW-1:0] LD_GAP  = PW'(CS_GAP - 1);
    localparam logic [BW-1:0] LD_BITS = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LO,
        SHIFT_HI,
        LAG,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_load;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  tx_shift;
    logic [N-1:0]  rx_shift;
    logic          miso_s1;
    logic          miso_s2;
    logic          sck_nxt;
    logic          cs_nxt;
    logic          busy_nxt;
    logic          phase_tc;

    assign phase_tc = (phase_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = LEAD;
            LEAD:     if (phase_tc) state_nxt = SHIFT_LO;
            SHIFT_LO: if (phase_tc) state_nxt = SHIFT_HI;
            SHIFT_HI: if (phase_tc) state_nxt = (bit_cnt == '0) ? LAG : SHIFT_LO;
            LAG:      if (phase_tc) state_nxt = GAP;
            GAP:      if (phase_tc) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        sck_nxt  = (state_nxt == SHIFT_HI);
        cs_nxt   = !((state_nxt == LEAD) || (state_nxt == SHIFT_LO) ||
                     (state_nxt == SHIFT_HI) || (state_nxt == LAG));
        busy_nxt = (state_nxt != IDLE);
    end

    always_comb begin
        case (state_nxt)
            LEAD:     phase_load = LD_LEAD;
            SHIFT_LO: phase_load = LD_DIV;
            SHIFT_HI: phase_load = LD_DIV;
            LAG:      phase_load = LD_LAG;
            GAP:      phase_load = LD_GAP;
            default:  phase_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SCK       <= 1'b0;
            CS        <= 1'b1;
            busy      <= 1'b0;
            MOSI      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
        end else begin
            SCK     <= sck_nxt;
            CS      <= cs_nxt;
            busy    <= busy_nxt;
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
            done    <= 1'b0;

            if (state_nxt != state) begin
                phase_cnt <= phase_load;
            end else if (state != IDLE) begin
                phase_cnt <= phase_cnt - PW'(1);
            end

            case (state)
                IDLE: begin
                    // MOSI carries the current bit; tx_shift holds the bits still to send.
                    if (start) begin
                        MOSI     <= tx_data[N-1];
                        tx_shift <= {tx_data[N-2:0], 1'b0};
                        bit_cnt  <= LD_BITS;
                    end
                end
                SHIFT_HI: begin
                    if (phase_cnt == LD_DIV) begin
                        rx_shift <= {rx_shift[N-2:0], miso_s2};
                    end
                    if (phase_tc) begin
                        if (bit_cnt == '0) begin
                            MOSI <= 1'b0;
                        end else begin
                            {MOSI, tx_shift} <= {tx_shift, 1'b0};
                            bit_cnt          <= bit_cnt - BW'(1);
                        end
                    end
                end
                LAG: begin
                    if (phase_tc) begin
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
